serv_ibus_prefetch: RTL and testbench

Instruction-fetch buffer between the misalignment handler's Wishbone master port and the servant arbiter's instruction port. It keeps the last demand-fetched word and speculatively fetches the next sequential word. Sequential fetches therefore hit locally, and the second word of a misaligned fetch can be served without a memory round trip.

---
 rtl/serv_ibus_prefetch.sv | 139 +++++++++++++
 tb/tb_serv_ibus_prefetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serv_ibus_prefetch.sv
// Two-entry instruction fetch buffer: a hold entry for the last demand-fetched word
// plus a speculative entry for the next sequential word.
module serv_ibus_prefetch #(
    parameter bit PREFETCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    output logic [31:0] o_wb_ibus_adr,
    output logic        o_wb_ibus_cyc,
    input  logic [31:0] i_wb_ibus_rdt,
    input  logic        i_wb_ibus_ack
);

    typedef enum logic [1:0] {IDLE, DEMAND, RESP, PREF} state_t;

    state_t      state_q, state_d;
    logic [29:0] hold_adr_q, hold_adr_d, pf_adr_q, pf_adr_d, req_adr_q, req_adr_d;
    logic [31:0] hold_dat_q, hold_dat_d, pf_dat_q, pf_dat_d, rdt_q, rdt_d;
    logic        hold_vld_q, hold_vld_d, pf_vld_q, pf_vld_d, drop_q, drop_d;

    logic [29:0] word;
    logic [29:0] hold_nxt;
    logic        hold_hit, pf_hit;
    logic        unused_adr_lsb;

    assign word           = i_ibus_adr[31:2];
    assign unused_adr_lsb = ^i_ibus_adr[1:0];
    assign hold_nxt       = hold_adr_q + 30'd1;
    assign hold_hit       = hold_vld_q && (hold_adr_q == word);
    assign pf_hit         = pf_vld_q && (pf_adr_q == word) && !hold_hit;

    always_comb begin
        state_d    = state_q;
        hold_adr_d = hold_adr_q;
        hold_dat_d = hold_dat_q;
        hold_vld_d = hold_vld_q;
        pf_adr_d   = pf_adr_q;
        pf_dat_d   = pf_dat_q;
        pf_vld_d   = pf_vld_q;
        req_adr_d  = req_adr_q;
        rdt_d      = rdt_q;
        drop_d     = drop_q;
        case (state_q)
            IDLE: begin
                if (i_ibus_cyc) begin
                    if (hold_hit) begin
                        rdt_d   = hold_dat_q;
                        state_d = RESP;
                    end else if (pf_hit) begin
                        // Promote the prefetched word so the next sequential fetch can follow it
                        rdt_d      = pf_dat_q;
                        hold_adr_d = pf_adr_q;
                        hold_dat_d = pf_dat_q;
                        hold_vld_d = 1'b1;
                        pf_vld_d   = 1'b0;
                        state_d    = RESP;
                    end else begin
                        req_adr_d = word;
                        drop_d    = 1'b0;
                        state_d   = DEMAND;
                    end
                end
            end
            DEMAND: begin
                if (i_wb_ibus_ack) begin
                    rdt_d = i_wb_ibus_rdt;
                    if (!drop_q) begin
                        hold_adr_d = req_adr_q;
                        hold_dat_d = i_wb_ibus_rdt;
                        hold_vld_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (PREFETCH && hold_vld_q && !(pf_vld_q && (pf_adr_q == hold_nxt))) begin
                    pf_adr_d = hold_nxt;
                    pf_vld_d = 1'b0;
                    drop_d   = 1'b0;
                    state_d  = PREF;
                end else begin
                    state_d = IDLE;
                end
            end
            PREF: begin
                if (i_wb_ibus_ack) begin
                    pf_dat_d = i_wb_ibus_rdt;
                    pf_vld_d = !drop_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides any store made this cycle; an in-flight word is marked stale
        if (i_flush) begin
            hold_vld_d = 1'b0;
            pf_vld_d   = 1'b0;
            if ((state_q == DEMAND) || (state_q == PREF)) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_adr_q <= '0;
            hold_dat_q <= '0;
            hold_vld_q <= 1'b0;
            pf_adr_q   <= '0;
            pf_dat_q   <= '0;
            pf_vld_q   <= 1'b0;
            req_adr_q  <= '0;
            rdt_q      <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_adr_q <= hold_adr_d;
            hold_dat_q <= hold_dat_d;
            hold_vld_q <= hold_vld_d;
            pf_adr_q   <= pf_adr_d;
            pf_dat_q   <= pf_dat_d;
            pf_vld_q   <= pf_vld_d;
            req_adr_q  <= req_adr_d;
            rdt_q      <= rdt_d;
            drop_q     <= drop_d;
        end
    end

    assign o_ibus_ack    = (state_q == RESP) && i_ibus_cyc;
    assign o_ibus_rdt    = rdt_q;
    assign o_wb_ibus_cyc = (state_q == DEMAND) || (state_q == PREF);
    assign o_wb_ibus_adr = (state_q == DEMAND) ? {req_adr_q, 2'b00} :
                           (state_q == PREF)   ? {pf_adr_q, 2'b00}  : 32'd0;

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// Directed bench for serv_ibus_prefetch: a memory model supplies the expected word for every
// upstream ack, plus hand-computed latency and downstream-address checks.
module tb_serv_ibus_prefetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_flush;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc, np_cyc;
    logic [31:0] rdt_o, wb_adr, wb_rdt, np_rdt, np_wb_adr, np_wb_rdt;
    logic        ack_o, wb_cyc, wb_ack, np_ack, np_wb_cyc, np_wb_ack;

    int          checks = 0, errors = 0;
    int          cyc_cnt = 0, wb_delay = 0, wb_ack_cyc = 0, ack_c = 0;
    logic [31:0] salt = 32'd0;
    logic [31:0] wb_log[$];
    logic [31:0] np_log[$];

    serv_ibus_prefetch #(.PREFETCH(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
        .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
        .o_ibus_rdt(rdt_o), .o_ibus_ack(ack_o),
        .o_wb_ibus_adr(wb_adr), .o_wb_ibus_cyc(wb_cyc),
        .i_wb_ibus_rdt(wb_rdt), .i_wb_ibus_ack(wb_ack));

    serv_ibus_prefetch #(.PREFETCH(1'b0)) dut_np (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
        .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(np_cyc),
        .o_ibus_rdt(np_rdt), .o_ibus_ack(np_ack),
        .o_wb_ibus_adr(np_wb_adr), .o_wb_ibus_cyc(np_wb_cyc),
        .i_wb_ibus_rdt(np_wb_rdt), .i_wb_ibus_ack(np_wb_ack));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Memory contents; salt models the image changing behind the buffer (e.g. before fence.i)
    function automatic logic [31:0] memval(input logic [29:0] w);
        if (w == 30'h40) return 32'h11111111 ^ salt;
        if (w == 30'h41) return 32'h22222222 ^ salt;
        return {w[15:0], ~w[15:0]} ^ salt;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i >= 0 && i < wb_log.size()) return wb_log[i];
        return 32'hBAD0BAD0;
    endfunction

    // Downstream memory: ack after wb_delay cycles of o_wb_ibus_cyc
    initial begin
        int cnt = 0;
        wb_ack = 1'b0; wb_rdt = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || wb_ack) begin
                wb_ack = 1'b0; cnt = 0;
            end else if (wb_cyc) begin
                if (cnt >= wb_delay) begin
                    wb_ack = 1'b1; wb_rdt = memval(wb_adr[31:2]);
                    wb_log.push_back(wb_adr); wb_ack_cyc = cyc_cnt;
                end else cnt++;
            end
        end
    end

    initial begin
        np_wb_ack = 1'b0; np_wb_rdt = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || np_wb_ack) np_wb_ack = 1'b0;
            else if (np_wb_cyc) begin
                np_wb_ack = 1'b1; np_wb_rdt = memval(np_wb_adr[31:2]);
                np_log.push_back(np_wb_adr);
            end
        end
    end

    // Every-cycle protocol and data checks against the memory model
    initial begin
        logic        p_cyc = 1'b0, p_ack = 1'b0;
        logic [31:0] p_adr = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ack_o) begin
                    chk("ack_rdt", rdt_o, memval(i_ibus_adr[31:2]));
                    chk("ack_needs_cyc", 32'(i_ibus_cyc), 32'd1);
                end
                if (np_ack) chk("np_ack_rdt", np_rdt, memval(i_ibus_adr[31:2]));
                if (wb_cyc) chk("wb_adr_align", 32'(wb_adr[1:0]), 32'd0);
                if (p_cyc && !p_ack) begin
                    chk("wb_cyc_held", 32'(wb_cyc), 32'd1);
                    chk("wb_adr_stable", wb_adr, p_adr);
                end
            end
            p_cyc = wb_cyc && rst_n; p_ack = wb_ack; p_adr = wb_adr;
        end
    end

    task automatic wait_ack(input bit np, output int k, output bit saw, output logic [31:0] r);
        k = -1; saw = 1'b0; r = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (np ? np_wb_cyc : wb_cyc) saw = 1'b1;
            if (np ? np_ack : ack_o) begin
                k = i; r = np ? np_rdt : rdt_o; ack_c = cyc_cnt;
                break;
            end
        end
        if (k < 0) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic fetch(input bit np, input logic [31:0] a, input int d,
                         output int k, output bit saw, output logic [31:0] r);
        wb_delay = d;
        @(posedge clk); #1;
        i_ibus_adr = a;
        if (np) np_cyc = 1'b1; else i_ibus_cyc = 1'b1;
        wait_ack(np, k, saw, r);
        @(posedge clk); #1;
        i_ibus_cyc = 1'b0; np_cyc = 1'b0;
    endtask

    task automatic settle();
        int quiet = 0;
        for (int i = 0; i < 200 && quiet < 3; i++) begin
            @(negedge clk);
            if (wb_cyc || np_wb_cyc) quiet = 0; else quiet++;
        end
        if (quiet < 3) chk("settle_timeout", 32'd0, 32'd1);
    endtask

    task automatic flush_pulse();
        @(posedge clk); #1; i_flush = 1'b1;
        @(posedge clk); #1; i_flush = 1'b0;
    endtask

    initial begin
        int          k, n0;
        bit          saw;
        logic [31:0] r;
        rst_n = 1'b0; i_flush = 1'b0; i_ibus_adr = 32'h100; i_ibus_cyc = 1'b1; np_cyc = 1'b0;

        // Reset with a request pending: everything quiet, then demand 0x100 and prefetch 0x104
        repeat (3) begin
            @(negedge clk);
            chk("rst_rdt", rdt_o | np_rdt, 32'd0);
            chk("rst_wb_adr", wb_adr | np_wb_adr, 32'd0);
            chk("rst_strobes", {28'd0, ack_o, wb_cyc, np_ack, np_wb_cyc}, 32'd0);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        wait_ack(1'b0, k, saw, r);
        chk("rst_miss_lat", 32'(k), 32'd2);
        chk("rst_rdt_val", r, 32'h11111111);
        @(posedge clk); #1; i_ibus_cyc = 1'b0;
        settle();
        chk("rst_wb_count", 32'(wb_log.size()), 32'd2);
        chk("rst_demand_adr", log_at(0), 32'h100);
        chk("rst_pref_adr", log_at(1), 32'h104);

        // Miss with slow memory, then hold hit, then prefetch hit with a misaligned address
        flush_pulse();
        n0 = wb_log.size();
        fetch(1'b0, 32'h100, 2, k, saw, r);
        chk("miss_lat", 32'(k), 32'd4);
        chk("miss_ack_after_wb", 32'(ack_c), 32'(wb_ack_cyc + 1));
        chk("miss_rdt", r, 32'h11111111);
        settle();
        chk("miss_pref_adr", log_at(n0 + 1), 32'h104);
        n0 = wb_log.size();
        fetch(1'b0, 32'h100, 2, k, saw, r);
        chk("hold_lat", 32'(k), 32'd1);
        chk("hold_no_cyc", 32'(saw), 32'd0);
        chk("hold_rdt", r, 32'h11111111);
        settle();
        chk("hold_no_wb", 32'(wb_log.size()), 32'(n0));
        fetch(1'b0, 32'h106, 2, k, saw, r);
        chk("pf_hit_lat", 32'(k), 32'd1);
        chk("pf_hit_no_cyc", 32'(saw), 32'd0);
        chk("pf_hit_rdt", r, 32'h22222222);

        // Request lands during the PREF of 0x108: served two cycles after the prefetch ack
        fetch(1'b0, 32'h108, 2, k, saw, r);
        chk("pf_wait_ack", 32'(ack_c), 32'(wb_ack_cyc + 2));
        chk("pf_wait_adr", log_at(n0), 32'h108);
        settle();
        chk("pf_next_adr", log_at(n0 + 1), 32'h10C);

        // Flush during PREF of 0x104: the in-flight word must not be used
        flush_pulse();
        fetch(1'b0, 32'h100, 2, k, saw, r);
        chk("fl_miss_lat", 32'(k), 32'd4);
        i_flush = 1'b1; salt = 32'h5A5A5A5A;
        @(posedge clk); #1; i_flush = 1'b0;
        settle();
        n0 = wb_log.size();
        fetch(1'b0, 32'h104, 0, k, saw, r);
        chk("fl_demand_lat", 32'(k), 32'd2);
        chk("fl_demand_adr", log_at(n0), 32'h104);
        chk("fl_rdt", r, 32'h22222222 ^ 32'h5A5A5A5A);
        settle();

        // Prefetch address wraps past the top of memory
        flush_pulse();
        n0 = wb_log.size();
        fetch(1'b0, 32'hFFFFFFFC, 0, k, saw, r);
        chk("wrap_lat", 32'(k), 32'd2);
        settle();
        chk("wrap_demand_adr", log_at(n0), 32'hFFFFFFFC);
        chk("wrap_pref_adr", log_at(n0 + 1), 32'h00000000);

        // Hold-only instance: sequential words each take a demand cycle, nothing speculative
        fetch(1'b1, 32'h200, 0, k, saw, r);
        chk("np_lat0", 32'(k), 32'd2);
        fetch(1'b1, 32'h204, 0, k, saw, r);
        chk("np_lat1", 32'(k), 32'd2);
        settle();
        chk("np_wb_count", 32'(np_log.size()), 32'd2);
        chk("np_adr0", (np_log.size() > 0) ? np_log[0] : 32'hBAD0BAD0, 32'h200);
        chk("np_adr1", (np_log.size() > 1) ? np_log[1] : 32'hBAD0BAD0, 32'h204);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
